// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer.
// Latches two WIDTH-bit operands and a 4-bit control code, then runs one bit per
// clock through a single 1-bit ALU slice (invert, AND/OR/add/less-select).
// Carry is chained between cycles. The final edge patches SLT into bit 0 and
// registers the result, zero, cout and overflow. done_o then pulses for one cycle.
module alu_serial_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ALU_control_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    // Working copies of the operands. They shift right so bit 0 is always the current bit.
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic [3:0]       ctrl;
    logic             carry;
    logic [CW-1:0]    cnt;
    // Result bits gathered so far. Each new bit enters at the top.
    // The final edge combines these bits with the slice output, so the register needs only WIDTH-1 bits.
    logic [WIDTH-2:0] work;

    logic             accept;
    logic             last;

    // Outputs of the 1-bit slice for the current bit.
    logic             bit_a;
    logic             bit_b;
    logic             bit_sum;
    logic             bit_carry;
    logic             bit_res;
    logic             bit_ovf;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] final_res;

    assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));
    assign busy_o = (state == RUN);
    assign done_o = (state == DONE);

    // One ALU slice: invert the inputs, then select AND, OR, sum or less (tied 0).
    always_comb begin
        bit_a     = a_shift[0] ^ ctrl[3];
        bit_b     = b_shift[0] ^ ctrl[2];
        bit_sum   = bit_a ^ bit_b ^ carry;
        bit_carry = (bit_a & bit_b) | (bit_a & carry) | (bit_b & carry);
        bit_ovf   = (bit_a & bit_b & ~bit_sum) | (~bit_a & ~bit_b & bit_sum);
        bit_res   = 1'b0;
        case (ctrl[1:0])
            2'b00:   bit_res = bit_a & bit_b;
            2'b01:   bit_res = bit_a | bit_b;
            2'b10:   bit_res = bit_sum;
            default: bit_res = 1'b0;
        endcase
        shifted   = {bit_res, work};
        // For SLT, the set signal (MSB sum) goes into bit 0 and all other bits are 0.
        if (ctrl[1:0] == 2'b11) begin
            final_res = {{(WIDTH-1){1'b0}}, bit_sum};
        end else begin
            final_res = shifted;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The edge that ends DONE also acts as an IDLE sample.
    // This lets a start_i held high issue back-to-back operations every WIDTH+1 cycles.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start_i) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture operands, step the slice each cycle, load the outputs on the last bit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            a_shift    <= '0;
            b_shift    <= '0;
            ctrl       <= '0;
            carry      <= 1'b0;
            cnt        <= '0;
            work       <= '0;
            result_o   <= '0;
            zero_o     <= 1'b0;
            cout_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else if (accept) begin
            a_shift <= src1_i;
            b_shift <= src2_i;
            ctrl    <= ALU_control_i;
            carry   <= ALU_control_i[2];
            cnt     <= '0;
        end else if (state == RUN) begin
            a_shift <= a_shift >> 1;
            b_shift <= b_shift >> 1;
            carry   <= bit_carry;
            cnt     <= cnt + CW'(1);
            work    <= shifted[WIDTH-1:1];
            if (last) begin
                result_o   <= final_res;
                zero_o     <= (final_res == '0);
                // cout and overflow are meaningful only for the adder-based ops (add, SLT).
                cout_o     <= ctrl[1] & bit_carry;
                overflow_o <= ctrl[1] & bit_ovf;
            end
        end
    end

endmodule
